// File: rtl/core_pkg.sv
// Shared types and constants for the integer core's hazard/flush control.
package core_pkg;

    localparam int unsigned WB_LAT    = 3;
    localparam int unsigned FLUSH_CYC = 2;
    localparam int unsigned REG_W     = 5;
    localparam int unsigned NREGS     = 32;

    typedef enum logic [REG_W-1:0] {
        OH_NOP  = 5'd0,
        OH_ADDI = 5'd1,
        OH_ADD  = 5'd2,
        OH_SUB  = 5'd3
    } oh_t;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    typedef struct packed {
        logic             v;
        logic [REG_W-1:0] rd;
    } sb_entry_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode-side request and pipeline-control response bundle of hazard_ctrl.
interface hazard_ctrl_if;
    import core_pkg::*;

    logic             id_valid;
    logic [REG_W-1:0] oh;
    logic [REG_W-1:0] rs1_addr;
    logic [REG_W-1:0] rs2_addr;
    logic [REG_W-1:0] rd_addr;
    logic             rd_wen;
    logic             flush_req;
    logic             stall;
    logic             bubble;
    logic             flush;
    logic [NREGS-1:0] busy_mask;
    logic [31:0]      stall_cnt;

    modport master (
        output id_valid, oh, rs1_addr, rs2_addr, rd_addr, rd_wen, flush_req,
        input  stall, bubble, flush, busy_mask, stall_cnt
    );

    modport slave (
        input  id_valid, oh, rs1_addr, rs2_addr, rd_addr, rd_wen, flush_req,
        output stall, bubble, flush, busy_mask, stall_cnt
    );

endinterface

// File: rtl/sb_shift.sv
// In-flight register-write scoreboard: one slot per stage between execute and writeback.
module sb_shift
    import core_pkg::*;
#(
    parameter int unsigned DEPTH = WB_LAT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  sb_entry_t        entry_in,
    output logic [NREGS-1:0] busy_mask
);

    sb_entry_t slots [DEPTH];

    // Advance every slot each cycle; slot 0 takes the entry issued from decode.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                slots[i] <= '0;
            end
        end else begin
            slots[0] <= entry_in;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                slots[i] <= slots[i-1];
            end
        end
    end

    // One-hot OR of pending destinations; x0 never reads as busy.
    always_comb begin
        busy_mask = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (slots[i].v) begin
                busy_mask[slots[i].rd] = 1'b1;
            end
        end
        busy_mask[0] = 1'b0;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage RAW stall, redirect flush sequencing and stall-cycle counter.
module hazard_ctrl
    import core_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    hazard_ctrl_if.slave hc
);

    localparam int unsigned FCNT_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam logic [FCNT_W-1:0] FCNT_LOAD = FCNT_W'(FLUSH_CYC - 1);

    state_t            state;
    logic [FCNT_W-1:0] fcnt;
    logic              flush_q;
    logic [31:0]       stall_cnt_q;
    logic [NREGS-1:0]  busy_mask;

    logic      use_c;
    logic      hazard_c;
    logic      issue_c;
    logic      stall_c;
    logic      bubble_c;
    sb_entry_t issue_entry;

    sb_shift #(.DEPTH(WB_LAT)) u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .entry_in  (issue_entry),
        .busy_mask (busy_mask)
    );

    // Hazard detect and same-cycle stall/bubble; redirect beats hazard beats issue.
    always_comb begin
        use_c       = hc.id_valid && (hc.oh != OH_NOP);
        hazard_c    = use_c && (busy_mask[hc.rs1_addr] || busy_mask[hc.rs2_addr]);
        stall_c     = 1'b0;
        bubble_c    = 1'b0;
        issue_c     = 1'b0;
        if (!rst_n) begin
            stall_c  = 1'b0;
        end else if ((state == ST_FLUSH) || hc.flush_req) begin
            bubble_c = 1'b1;
        end else if (hazard_c) begin
            stall_c  = 1'b1;
            bubble_c = 1'b1;
        end else begin
            issue_c  = use_c;
        end
        issue_entry.v  = issue_c && hc.rd_wen && (hc.rd_addr != 5'd0);
        issue_entry.rd = hc.rd_addr;
    end

    // Flush sequencer and saturating stall counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_RUN;
            fcnt        <= '0;
            flush_q     <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (hc.flush_req) begin
                        state   <= ST_FLUSH;
                        fcnt    <= FCNT_LOAD;
                        flush_q <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if (hc.flush_req) begin
                        fcnt <= FCNT_LOAD;
                    end else if (fcnt == '0) begin
                        state   <= ST_RUN;
                        flush_q <= 1'b0;
                    end else begin
                        fcnt <= fcnt - FCNT_W'(1);
                    end
                end
                default: begin
                    state   <= ST_RUN;
                    flush_q <= 1'b0;
                end
            endcase
            if (stall_c && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign hc.stall     = stall_c;
    assign hc.bubble    = bubble_c;
    assign hc.flush     = flush_q && rst_n;
    assign hc.busy_mask = busy_mask;
    assign hc.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl.
module tb_hazard_ctrl;
    import core_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    hazard_ctrl_if hc ();

    hazard_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hc    (hc.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic        stall;
        logic        bubble;
        logic        flush;
        logic [31:0] mask;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   vid   = 0;
    exp_t mon_e;

    // Drive one cycle of inputs (just after posedge) and queue the expected response.
    task automatic apply(input logic rst, input logic v, input logic [4:0] op,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic wen, input logic fr,
                         input logic es, input logic eb, input logic ef,
                         input logic [31:0] em, input logic [31:0] ec);
        exp_t e;
        rst_n        = rst;
        hc.id_valid  = v;
        hc.oh        = op;
        hc.rs1_addr  = rs1;
        hc.rs2_addr  = rs2;
        hc.rd_addr   = rd;
        hc.rd_wen    = wen;
        hc.flush_req = fr;
        e.id     = vid;
        e.stall  = es;
        e.bubble = eb;
        e.flush  = ef;
        e.mask   = em;
        e.cnt    = ec;
        exp_q.push_back(e);
        vid++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [31:0] em, input logic [31:0] ec);
        apply(1, 0, OH_NOP, 0, 0, 0, 0, 0, 0, 0, 0, em, ec);
    endtask

    // Monitor: compare the DUT against the oldest queued expectation at each negedge.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            n_vec++;
            if ({hc.stall, hc.bubble, hc.flush, hc.busy_mask, hc.stall_cnt} !==
                {mon_e.stall, mon_e.bubble, mon_e.flush, mon_e.mask, mon_e.cnt}) begin
                n_bad++;
                $display("FAIL vec%0d: got stall=%b bubble=%b flush=%b busy=%h cnt=%0d, want stall=%b bubble=%b flush=%b busy=%h cnt=%0d",
                         mon_e.id, hc.stall, hc.bubble, hc.flush, hc.busy_mask, hc.stall_cnt,
                         mon_e.stall, mon_e.bubble, mon_e.flush, mon_e.mask, mon_e.cnt);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        hc.id_valid  = 1'b0;
        hc.oh        = '0;
        hc.rs1_addr  = '0;
        hc.rs2_addr  = '0;
        hc.rd_addr   = '0;
        hc.rd_wen    = 1'b0;
        hc.flush_req = 1'b0;
        rst_n        = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Held in reset with a hazard-looking op and flush_req: controls forced low.
        apply(0, 1, OH_ADD, 1, 2, 3, 1, 1, 0, 0, 0, 32'h0, 0);

        // Independent pair: no stall, busy_mask 0x2 then 0xA, then drains.
        apply(1, 1, OH_ADDI, 0, 0, 1, 1, 0, 0, 0, 0, 32'h0, 0);
        apply(1, 1, OH_ADD,  4, 5, 3, 1, 0, 0, 0, 0, 32'h2, 0);
        idle(32'hA, 0);
        idle(32'hA, 0);
        idle(32'h8, 0);
        idle(32'h0, 0);

        // Back-to-back RAW: three stall cycles, then issue.
        apply(1, 1, OH_ADDI, 0, 0, 1, 1, 0, 0, 0, 0, 32'h0, 0);
        apply(1, 1, OH_ADD,  1, 1, 2, 1, 0, 1, 1, 0, 32'h2, 0);
        apply(1, 1, OH_ADD,  1, 1, 2, 1, 0, 1, 1, 0, 32'h2, 1);
        apply(1, 1, OH_ADD,  1, 1, 2, 1, 0, 1, 1, 0, 32'h2, 2);
        apply(1, 1, OH_ADD,  1, 1, 2, 1, 0, 0, 0, 0, 32'h0, 3);
        idle(32'h4, 3);
        idle(32'h4, 3);
        idle(32'h4, 3);
        idle(32'h0, 3);

        // Writes to x0 never pend.
        apply(1, 1, OH_ADDI, 0, 0, 0, 1, 0, 0, 0, 0, 32'h0, 3);
        apply(1, 1, OH_ADD,  0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 3);
        idle(32'h0, 3);

        // Redirect during a stall; consumer held valid through the flush.
        apply(1, 1, OH_ADDI, 0, 0, 7, 1, 0, 0, 0, 0, 32'h0,  3);
        apply(1, 1, OH_ADD,  7, 0, 8, 1, 0, 1, 1, 0, 32'h80, 3);
        apply(1, 1, OH_ADD,  7, 0, 8, 1, 1, 0, 1, 0, 32'h80, 4);
        apply(1, 1, OH_ADD,  7, 0, 8, 1, 0, 0, 1, 1, 32'h80, 4);
        apply(1, 1, OH_ADD,  7, 0, 8, 1, 0, 0, 1, 1, 32'h0,  4);
        apply(1, 1, OH_ADD,  7, 0, 8, 1, 0, 0, 0, 0, 32'h0,  4);
        idle(32'h100, 4);
        idle(32'h100, 4);
        idle(32'h100, 4);
        idle(32'h0,   4);

        // flush_req held three cycles: flush stays high four cycles.
        apply(1, 0, OH_NOP, 0, 0, 0, 0, 1, 0, 1, 0, 32'h0, 4);
        apply(1, 0, OH_NOP, 0, 0, 0, 0, 1, 0, 1, 1, 32'h0, 4);
        apply(1, 0, OH_NOP, 0, 0, 0, 0, 1, 0, 1, 1, 32'h0, 4);
        apply(1, 0, OH_NOP, 0, 0, 0, 0, 0, 0, 1, 1, 32'h0, 4);
        apply(1, 0, OH_NOP, 0, 0, 0, 0, 0, 0, 1, 1, 32'h0, 4);
        idle(32'h0, 4);

        // Reset asserted for one cycle mid-stall discards everything.
        apply(1, 1, OH_ADDI, 0, 0, 9, 1, 0, 0, 0, 0, 32'h0,   4);
        apply(1, 1, OH_SUB,  9, 0, 10, 1, 0, 1, 1, 0, 32'h200, 4);
        apply(0, 1, OH_SUB,  9, 0, 10, 1, 0, 0, 0, 0, 32'h200, 5);
        apply(1, 1, OH_SUB,  9, 0, 10, 1, 0, 0, 0, 0, 32'h0,   0);
        idle(32'h400, 0);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
            @(posedge clk);
        end
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
